// File: rtl/chimp_board_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : chimp_board_renderer
//  Purpose  : Scans the 8x8 chimp-game board one cell at a time and paints
//             every cell into the 160x120 VGA framebuffer, one pixel-write
//             per clock. A start pulse begins a full redraw and a one-cycle
//             done pulse marks its end.
//  Ports    : clk      - system clock
//             iKey0    - synchronous active-high reset
//             iStart   - one-cycle pulse that begins a full-board redraw
//             iCell    - cell word at (oCellX, oCellY):
//                        [6] active, [5] showing, [4:0] number
//             oCellX/Y - board column/row being read
//             oX/oY    - framebuffer pixel address
//             oColour  - RGB pixel colour
//             oPlot    - pixel write strobe
//             oBusy    - redraw in progress
//             oDone    - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module chimp_board_renderer #(
    parameter int BOARD_X0   = 20,
    parameter int BOARD_Y0   = 0,
    parameter int CELL_PITCH = 15
) (
    input  logic       clk,
    input  logic       iKey0,
    input  logic       iStart,
    input  logic [6:0] iCell,
    output logic [2:0] oCellX,
    output logic [2:0] oCellY,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last pixel index within a cell; the final row/column is the gap.
    localparam logic [3:0] C_LAST = 4'(CELL_PITCH - 1);

    localparam logic [2:0] C_BLACK = 3'b000;
    localparam logic [2:0] C_WHITE = 3'b111;
    localparam logic [2:0] C_BLUE  = 3'b001;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cx;
    logic [2:0] r_cy;
    logic [3:0] r_px;
    logic [3:0] r_py;
    logic [6:0] r_cell;

    // 3x5 font: rows concatenated top to bottom, leftmost column in the MSB,
    // so pixel (col,row) sits at bit 14 - (row*3 + col).
    function automatic logic [14:0] f_font(input logic [4:0] d);
        logic [14:0] g;
        case (d)
            5'd0:    g = 15'b111_101_101_101_111;
            5'd1:    g = 15'b010_110_010_010_111;
            5'd2:    g = 15'b111_001_111_100_111;
            5'd3:    g = 15'b111_001_111_001_111;
            5'd4:    g = 15'b101_101_111_001_001;
            5'd5:    g = 15'b111_100_111_001_111;
            5'd6:    g = 15'b111_100_111_101_111;
            5'd7:    g = 15'b111_001_001_001_001;
            5'd8:    g = 15'b111_101_111_101_111;
            5'd9:    g = 15'b111_101_111_001_111;
            default: g = 15'b000_000_000_000_000;
        endcase
        return g;
    endfunction

    // Padded to 16 bits so an out-of-glyph index (only evaluated when the
    // region test is false) still lands inside the vector.
    function automatic logic f_glyph(input logic [14:0] g,
                                     input logic [3:0]  col,
                                     input logic [3:0]  row);
        logic [15:0] gx;
        logic [3:0]  idx;
        gx  = {1'b0, g};
        idx = 4'd14 - (row * 4'd3 + col);
        return gx[idx];
    endfunction

    // ------------------------------------------------------------------
    // State register and scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (iKey0) begin
            r_state <= S_IDLE;
            r_cx    <= 3'd0;
            r_cy    <= 3'd0;
            r_px    <= 4'd0;
            r_py    <= 4'd0;
            r_cell  <= 7'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_cx <= 3'd0;
                        r_cy <= 3'd0;
                    end
                end
                S_LATCH: begin
                    r_cell <= iCell;
                    r_px   <= 4'd0;
                    r_py   <= 4'd0;
                end
                S_DRAW: begin
                    if (r_px == C_LAST) begin
                        r_px <= 4'd0;
                        if (r_py == C_LAST) begin
                            r_py <= 4'd0;
                            // Column is the inner cell loop; both wrap to 0
                            // after the last cell.
                            r_cx <= r_cx + 3'd1;
                            if (r_cx == 3'd7) begin
                                r_cy <= r_cy + 3'd1;
                            end
                        end else begin
                            r_py <= r_py + 4'd1;
                        end
                    end else begin
                        r_px <= r_px + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = S_DRAW;
            end
            S_DRAW: begin
                if (r_px == C_LAST && r_py == C_LAST) begin
                    if (r_cx == 3'd7 && r_cy == 3'd7) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_LATCH;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic       w_draw;
    logic       w_gap;
    logic [4:0] w_num;
    logic [4:0] w_tens;
    logic [4:0] w_units;
    logic       w_in_tens;
    logic       w_in_units;
    logic       w_tens_on;
    logic       w_units_on;
    logic [2:0] w_colour;
    logic [7:0] w_x;
    logic [6:0] w_y;

    assign w_draw = (r_state == S_DRAW);
    assign w_gap  = (r_px == C_LAST) || (r_py == C_LAST);
    assign w_num  = r_cell[4:0];

    // Numbers stop at 31, so a compare chain replaces a divider.
    assign w_tens  = (w_num >= 5'd30) ? 5'd3 :
                     (w_num >= 5'd20) ? 5'd2 :
                     (w_num >= 5'd10) ? 5'd1 : 5'd0;
    assign w_units = w_num - w_tens * 5'd10;

    assign w_in_tens  = (r_px >= 4'd3) && (r_px <= 4'd5) &&
                        (r_py >= 4'd5) && (r_py <= 4'd9);
    assign w_in_units = (r_px >= 4'd8) && (r_px <= 4'd10) &&
                        (r_py >= 4'd5) && (r_py <= 4'd9);

    // A leading zero is suppressed: single-digit numbers show only units.
    assign w_tens_on  = w_in_tens && (w_tens != 5'd0) &&
                        f_glyph(f_font(w_tens), r_px - 4'd3, r_py - 4'd5);
    assign w_units_on = w_in_units &&
                        f_glyph(f_font(w_units), r_px - 4'd8, r_py - 4'd5);

    always_comb begin
        w_colour = C_BLACK;
        if (w_draw && !w_gap && r_cell[6]) begin
            if (!r_cell[5]) begin
                w_colour = C_WHITE;
            end else if (w_tens_on || w_units_on) begin
                w_colour = C_WHITE;
            end else begin
                w_colour = C_BLUE;
            end
        end
    end

    assign w_x = 8'(BOARD_X0 + CELL_PITCH * int'(r_cx) + int'(r_px));
    assign w_y = 7'(BOARD_Y0 + CELL_PITCH * int'(r_cy) + int'(r_py));

    // Address and colour are forced to zero outside DRAW so the bus is
    // quiet whenever no pixel is being written.
    assign oX      = w_draw ? w_x : 8'd0;
    assign oY      = w_draw ? w_y : 7'd0;
    assign oColour = w_colour;
    assign oPlot   = w_draw;
    assign oBusy   = (r_state == S_LATCH) || w_draw;
    assign oDone   = (r_state == S_DONE);
    assign oCellX  = r_cx;
    assign oCellY  = r_cy;

endmodule
`default_nettype wire

// File: doc/chimp_board_renderer.md
# chimp_board_renderer

Reads the 8×8 chimp-game board one cell at a time and paints it into the 160×120 VGA framebuffer. It is the read side of the chimp board: the chimp datapath writes each cell's active/showing/number fields, and this block scans them and emits one pixel-write per clock to the VGA adapter. A full redraw starts on a single start pulse and ends with a single done pulse.

## Interface
Parameters:
- BOARD_X0, 20, framebuffer x of the board's left edge
- BOARD_Y0, 0, framebuffer y of the board's top edge
- CELL_PITCH, 15, pixel pitch per cell (14 interior + 1 gap)

Ports:
- clk  in  1  system clock, single clock domain
- iKey0  in  1  synchronous active-high reset
- iStart  in  1  one-cycle pulse that begins a full-board redraw
- iCell  in  7  cell word at (oCellX, oCellY): [6] active, [5] showing, [4:0] number 0–31
- oCellX  out  3  board column being read
- oCellY  out  3  board row being read
- oX  out  8  framebuffer x
- oY  out  7  framebuffer y
- oColour  out  3  RGB pixel colour
- oPlot  out  1  pixel write strobe
- oBusy  out  1  redraw in progress
- oDone  out  1  one-cycle pulse when the redraw is complete

## Operation
- FSM states are IDLE, LATCH, DRAW and DONE.
  - IDLE: iStart → LATCH with cx = cy = 0.
  - LATCH (1 cycle): capture iCell into a cell register. Go to DRAW with px = py = 0.
  - DRAW (225 cycles): one pixel per cycle. px is the inner loop 0..14, py the outer loop 0..14.
  - After px = py = 14: advance the cell (cx is inner, cy outer) → LATCH. After cell (7,7) → DONE.
  - DONE (1 cycle): → IDLE.
- oCellX = cx and oCellY = cy. They are stable through LATCH and DRAW of each cell. iCell is sampled only at the end of LATCH.
- Pixel address:
  - oX = BOARD_X0 + CELL_PITCH·cx + px
  - oY = BOARD_Y0 + CELL_PITCH·cy + py
  - Computed at full width; no wrap with the defaults (max 139, 119).
- Colour rules, first match wins:
  - px = 14 or py = 14 (gap) → 000.
  - active = 0 → 000.
  - active = 1, showing = 0 → 111 (hidden tile).
  - active = 1, showing = 1 → background 001; digit pixels → 111.
- Digits:
  - tens = number / 10 (0–3), units = number % 10.
  - Tens glyph occupies px 3–5, py 5–9, and is drawn only when tens ≠ 0.
  - Units glyph occupies px 8–10, py 5–9.
- Font is a 3×5 ROM, 15 bits per digit 0–9. Glyph pixel (col, row) uses bit 14 − (row·3 + col). Standard seven-segment-style shapes, e.g. 1 = 010 110 010 010 111 by rows.
- oPlot = 1 in every DRAW cycle, black pixels included (the frame is cleared), and 0 otherwise.
- oBusy = 1 in LATCH and DRAW. oDone = 1 only in DONE.
- iStart while not in IDLE is ignored.

## Timing
- Reset values: state IDLE; oX = 0, oY = 0, oColour = 0, oPlot = 0, oBusy = 0, oDone = 0, oCellX = 0, oCellY = 0.
- Outputs are Moore outputs of the registered state and counters.
- iStart sampled at edge E → LATCH in cycle E+1. First oPlot in cycle E+2.
- Per cell: 226 cycles. Whole frame: 64 × 226 = 14464 cycles. oDone is high in cycle E+14465; the FSM is in IDLE at E+14466.
- Total oPlot count per frame is exactly 14400.
- Reset mid-frame: IDLE on the next edge, oPlot = 0, no oDone. Reset and iStart in the same cycle: reset wins.
- iStart in the DONE cycle is ignored. iStart in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset, then idle 20 cycles → all outputs 0; no oPlot.
- All-zero board, iStart → exactly 14400 oPlot with oColour = 000; oDone one cycle at start+14465; oBusy falls when the FSM enters DONE.
- Cell (0,0) = 7'b1000000 (active, hidden), others 0 → (20..33, 0..13) = 111; (34,0) and (20,14) = 000.
- Cell (7,7) = {1,1,5'd27} → background at (125,105) = 001; tens "2" and units "7" glyph pixels at px 3–5 and 8–10, py 5–9 = 111. Cell (3,2) = {1,1,5'd5} → px 3–5 all 001 (no tens glyph).
- iStart pulsed again at cycle 1000 of a frame → ignored; oDone still at start+14465; only one frame drawn.
- iKey0 asserted at cycle 500 → oPlot = 0 next cycle, no oDone. A new iStart then produces a full 14400-plot frame.
